alu_issue_arbiter: RTL and testbench
====================================

# alu_issue_arbiter

Two-port arbiter and sequencer that shares the single registered `alu` between two requesters (e.g. execute stage and address/branch unit). It accepts one operation at a time by valid/ready handshake, grants round-robin, drives ALU operands and opcode, captures the 64-bit result and the [SZNVC] flags one cycle after the ALU's registering edge, and returns them to the winning requester. Opcodes the ALU does not decode are rejected without using the ALU.

## Interface
- `DATA_SIZE`, 32: operand width; the result is `2*DATA_SIZE` bits.
- `OP_W`, 6: opcode width, encoded {class[2:0], func[2:0]}.
- `clkout` in 1: system clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): request present.
- `reqN_ready` out 1: single-cycle accept pulse.
- `reqN_a`, `reqN_b` in DATA_SIZE: operands.
- `reqN_op` in OP_W: opcode.
- `rspN_valid` out 1: response present.
- `rspN_ready` in 1: response consumed.
- `rspN_result` out 2*DATA_SIZE: result.
- `rspN_flags` out 5: [SZNVC].
- `rspN_err` out 1: illegal opcode.
- `alu_a`, `alu_b` out DATA_SIZE: ALU operands.
- `alu_op` out OP_W: ALU opcode.
- `alu_result` in 2*DATA_SIZE: registered ALU result.
- `alu_flags` in 5: registered ALU flags.
- `busy` out 1: state is not IDLE.
- `grant_id` out 1: requester currently owning the ALU.

## Operation
- States: IDLE, EXEC, CAPT, RESP.
- IDLE, with a legal request:
  - Pick the winner: the `prio` pointer breaks ties, a lone requester always wins.
  - Pulse its `reqN_ready`, load `alu_a`/`alu_b`/`alu_op`, set `grant_id`, go to EXEC.
- IDLE, with an illegal winner opcode:
  - Pulse ready, load a response of result=0, flags=0, err=1, go straight to RESP. The ALU inputs are left unchanged.
- EXEC: hold ALU inputs stable; the ALU samples them at the end of this cycle. Go to CAPT.
- CAPT: register `alu_result`/`alu_flags` into the granted requester's response regs with err=0. Go to RESP.
- RESP:
  - Hold `rspN_valid` (granted N only) with stable data until `rspN_ready`=1.
  - On that edge, drop valid, set `prio` = ~`grant_id`, return to IDLE.
- Legal opcodes:
  - 001_001 through 001_111;
  - 010_001 through 010_110;
  - 011_000 through 011_111.
  - Everything else is illegal.
- Only one operation is in flight; the loser's valid stays pending, and its inputs must remain stable until its ready pulse.
- MUL uses the same path and timing as every other operation; there is no multi-cycle special case.

## Timing
- Reset values:
  - state=IDLE, `prio`=0 (req0 wins ties), `grant_id`=0;
  - all ready/valid/err=0, `alu_a`/`alu_b`/`alu_op`=0, response data=0, `busy`=0.
- Reset mid-operation aborts the transaction with no response; the ALU output is ignored.
- Legal latency: accept edge T; `rspN_valid` is high from T+3. With `rspN_ready` held high, the next accept can occur at T+4, so throughput is one op per 4 cycles.
- Illegal latency: `rspN_valid` is high from T+1, and the next accept can come at T+2.
- `reqN_ready` is never asserted outside IDLE and never to both requesters in the same cycle.
- `rspN_valid` with `rspN_ready` already high at entry to RESP: consumed on the first RESP edge.
- Simultaneous valid on both ports: grant requester `prio`. Back-to-back alternation is guaranteed when both stay asserted.
- A request arriving during EXEC, CAPT or RESP waits; it is never dropped.

## Structure
- Package `alu_ctrl_pkg`:
  - state enum;
  - opcode localparams (OP_ADD=6'b001_001, OP_MUL=6'b001_111, OP_CLR=6'b011_111, ...);
  - function `op_legal(op)`;
  - flag bit indices S=4, Z=3, N=2, V=1, C=0.
- Optional sub-module `rr_arb2`: combinational two-way round-robin pick from valids plus `prio`.
- The ALU is instantiated outside this block; this block only drives and samples its ports.

## Test plan
- Reset mid-RESP with rsp0 pending -> all outputs 0, state IDLE, no response; next req0 is served normally.
- req0 ADD a=5 b=7 alone -> `req0_ready` at T, `alu_op`=001_001 during EXEC, `rsp0_valid` at T+3 with result=12, flags Z=0, err=0.
- req0 and req1 valid together after reset, both held -> order 0,1,0,1 by `grant_id`; each response goes only to its own port.
- req1 op=6'b000_000 -> `rsp1_valid` at T+1 with err=1, result=0, flags=0; `alu_op` unchanged.
- rsp0_ready held low 5 cycles with req1 pending -> `rsp0_valid` and data stable 5 cycles, `req1_ready` not asserted; req1 accepted on the first IDLE cycle after consume.
- MUL a=32'hFFFF_FFFF b=2 -> `rsp_result` equals captured `alu_result` (64'h1_FFFF_FFFE) at T+3.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared state, opcode and flag definitions for the ALU issue arbiter
package alu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  localparam logic [5:0] OP_NOP = 6'b000_000;
  localparam logic [5:0] OP_ADD = 6'b001_001;
  localparam logic [5:0] OP_MUL = 6'b001_111;
  localparam logic [5:0] OP_CLR = 6'b011_111;
  localparam int FLAG_S = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  function automatic logic op_legal(input logic [5:0] op);
    return (op[5:3] == 3'd1 && op[2:0] != 3'd0) ||
           (op[5:3] == 3'd2 && op[2:0] != 3'd0 && op[2:0] != 3'd7) ||
           (op[5:3] == 3'd3);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; prio breaks ties, a lone requester always wins
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       any,
  output logic       id
);
  assign any = |valid;
  assign id  = &valid ? prio : valid[1];
endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: shares one registered ALU between two requesters, one op in flight
module alu_issue_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int OP_W      = 6
) (
  input  logic                   clkout,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [DATA_SIZE-1:0]   req0_a,
  input  logic [DATA_SIZE-1:0]   req0_b,
  input  logic [OP_W-1:0]        req0_op,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [DATA_SIZE-1:0]   req1_a,
  input  logic [DATA_SIZE-1:0]   req1_b,
  input  logic [OP_W-1:0]        req1_op,
  output logic                   rsp0_valid,
  input  logic                   rsp0_ready,
  output logic [2*DATA_SIZE-1:0] rsp0_result,
  output logic [4:0]             rsp0_flags,
  output logic                   rsp0_err,
  output logic                   rsp1_valid,
  input  logic                   rsp1_ready,
  output logic [2*DATA_SIZE-1:0] rsp1_result,
  output logic [4:0]             rsp1_flags,
  output logic                   rsp1_err,
  output logic [DATA_SIZE-1:0]   alu_a,
  output logic [DATA_SIZE-1:0]   alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [2*DATA_SIZE-1:0] alu_result,
  input  logic [4:0]             alu_flags,
  output logic                   busy,
  output logic                   grant_id
);
  state_t state_q, state_d;
  logic prio_q, prio_d, grant_q, grant_d;
  logic [DATA_SIZE-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [2*DATA_SIZE-1:0] res_q [2];
  logic [2*DATA_SIZE-1:0] res_d [2];
  logic [4:0] flg_q [2];
  logic [4:0] flg_d [2];
  logic [1:0] err_q, err_d;
  logic any_v, win, accept, rsp_take;
  logic [DATA_SIZE-1:0] win_a, win_b;
  logic [OP_W-1:0] win_op;

  rr_arb2 u_arb (
    .valid ({req1_valid, req0_valid}),
    .prio  (prio_q),
    .any   (any_v),
    .id    (win)
  );

  assign win_a    = win ? req1_a : req0_a;
  assign win_b    = win ? req1_b : req0_b;
  assign win_op   = win ? req1_op : req0_op;
  assign accept   = state_q == IDLE && any_v;
  assign rsp_take = grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    grant_d  = grant_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    flg_d    = flg_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (any_v) begin
        grant_d = win;
        if (op_legal(win_op)) begin
          alu_a_d  = win_a;
          alu_b_d  = win_b;
          alu_op_d = win_op;
          state_d  = EXEC;
        end else begin
          // rejected ops never touch the ALU; the error response is ready immediately
          res_d[win] = '0;
          flg_d[win] = '0;
          err_d[win] = 1'b1;
          state_d    = RESP;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: begin
        res_d[grant_q] = alu_result;
        flg_d[grant_q] = alu_flags;
        err_d[grant_q] = 1'b0;
        state_d        = RESP;
      end
      RESP: if (rsp_take) begin
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      grant_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '{default: '0};
      flg_q    <= '{default: '0};
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      grant_q  <= grant_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      err_q    <= err_d;
    end
  end

  assign req0_ready  = accept && !win;
  assign req1_ready  = accept && win;
  assign rsp0_valid  = state_q == RESP && !grant_q;
  assign rsp1_valid  = state_q == RESP && grant_q;
  assign rsp0_result = res_q[0];
  assign rsp1_result = res_q[1];
  assign rsp0_flags  = flg_q[0];
  assign rsp1_flags  = flg_q[1];
  assign rsp0_err    = err_q[0];
  assign rsp1_err    = err_q[1];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign busy        = state_q != IDLE;
  assign grant_id    = grant_q;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: directed vector table plus hand sequences for arbitration, stall and reset
module tb_alu_issue_arbiter;
  import alu_ctrl_pkg::*;
  logic clkout = 1'b0, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [5:0] req0_op, req1_op, alu_op;
  logic rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [63:0] rsp0_result, rsp1_result, alu_result;
  logic [4:0] rsp0_flags, rsp1_flags, alu_flags;
  logic busy, grant_id;
  int n_cmp = 0, n_bad = 0;
  logic [5:0] last_op;

  always #5 clkout = ~clkout;

  alu_issue_arbiter dut (
    .clkout(clkout), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(busy), .grant_id(grant_id)
  );

  // stand-in registered ALU: ADD, MUL, anything else XOR; only Z flag modelled
  function automatic logic [63:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    return op == OP_ADD ? {32'd0, a} + {32'd0, b} : op == OP_MUL ? {32'd0, a} * {32'd0, b} : {32'd0, a ^ b};
  endfunction

  always @(posedge clkout) begin
    alu_result <= alu_fn(alu_a, alu_b, alu_op);
    alu_flags  <= {1'b0, alu_fn(alu_a, alu_b, alu_op) == 64'd0, 3'b000};
  end

  typedef struct {
    bit p; logic [31:0] a; logic [31:0] b; logic [5:0] op;
    logic [63:0] res; logic [4:0] flg; logic err; int lat;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    if (p) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
    else begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  task automatic run_req(input vec_t t);
    int cnt;
    @(negedge clkout);
    drive(t.p, 1'b1, t.a, t.b, t.op);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    chk("req_ready", t.p ? req1_ready : req0_ready, 1);
    chk("other_ready", t.p ? req0_ready : req1_ready, 0);
    @(posedge clkout);
    #1 drive(t.p, 1'b0, 32'd0, 32'd0, 6'd0);
    for (cnt = 1; cnt <= 8; cnt++) begin
      @(negedge clkout);
      if (cnt == 1) chk("alu_op", alu_op, t.err ? last_op : t.op);
      if (t.p ? rsp1_valid : rsp0_valid) break;
    end
    chk("latency", cnt, t.lat);
    chk("grant_id", grant_id, t.p);
    chk("rsp_result", t.p ? rsp1_result : rsp0_result, t.res);
    chk("rsp_flags", t.p ? rsp1_flags : rsp0_flags, t.flg);
    chk("rsp_err", t.p ? rsp1_err : rsp0_err, t.err);
    chk("other_rsp_valid", t.p ? rsp0_valid : rsp1_valid, 0);
    @(posedge clkout);
    #1;
    chk("rsp_dropped", t.p ? rsp1_valid : rsp0_valid, 0);
    chk("idle_after", busy, 0);
    if (!t.err) last_op = t.op;
  endtask

  task automatic wait_rsp(input bit p, input string nm);
    int cnt;
    for (cnt = 0; cnt < 10 && !(p ? rsp1_valid : rsp0_valid); cnt++) @(negedge clkout);
    chk(nm, cnt < 10, 1);
  endtask

  initial begin
    vt[0] = '{1'b0, 32'd5, 32'd7, OP_ADD, 64'd12, 5'b00000, 1'b0, 3};
    vt[1] = '{1'b1, 32'd0, 32'd0, OP_ADD, 64'd0, 5'b01000, 1'b0, 3};
    vt[2] = '{1'b0, 32'hFFFF_FFFF, 32'd2, OP_MUL, 64'h1_FFFF_FFFE, 5'b00000, 1'b0, 3};
    vt[3] = '{1'b1, 32'd0, 32'd0, 6'b000_000, 64'd0, 5'b00000, 1'b1, 1};
    vt[4] = '{1'b0, 32'd1, 32'd1, 6'b001_000, 64'd0, 5'b00000, 1'b1, 1};
    vt[5] = '{1'b1, 32'd3, 32'd5, 6'b010_111, 64'd0, 5'b00000, 1'b1, 1};
    vt[6] = '{1'b0, 32'd3, 32'd5, 6'b010_110, 64'd6, 5'b00000, 1'b0, 3};
    vt[7] = '{1'b1, 32'd9, 32'd9, OP_CLR, 64'd0, 5'b01000, 1'b0, 3};
    vt[8] = '{1'b0, 32'd1, 32'd2, 6'b011_000, 64'd3, 5'b00000, 1'b0, 3};
    vt[9] = '{1'b1, 32'd4, 32'd4, 6'b111_000, 64'd0, 5'b00000, 1'b1, 1};
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 6'd0);
    drive(1'b1, 1'b0, 32'd0, 32'd0, 6'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    last_op = 6'd0;
    repeat (2) @(posedge clkout);
    @(negedge clkout);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_err", {rsp0_err, rsp1_err}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) run_req(vt[i]);

    // both requesters held: strict alternation starting at req0 after reset
    @(negedge clkout) rst = 1'b1;
    @(negedge clkout) rst = 1'b0;
    drive(1'b0, 1'b1, 32'd1, 32'd1, OP_ADD);
    drive(1'b1, 1'b1, 32'd10, 32'd20, OP_ADD);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int cnt;
      bit e;
      e = g[0];
      #1;
      for (cnt = 0; cnt < 10 && !(req0_ready || req1_ready); cnt++) begin
        @(negedge clkout);
        #1;
      end
      chk("rr_accept_seen", cnt < 10, 1);
      chk("rr_winner", req1_ready, e);
      chk("rr_not_both", req0_ready && req1_ready, 0);
      @(posedge clkout);
      #1;
      if (g == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      chk("rr_grant_id", grant_id, e);
      @(negedge clkout);
      wait_rsp(e, "rr_rsp_seen");
      chk("rr_result", e ? rsp1_result : rsp0_result, e ? 64'd30 : 64'd2);
      chk("rr_other_valid", e ? rsp0_valid : rsp1_valid, 0);
      @(posedge clkout);
      @(negedge clkout);
    end

    // stalled response with req1 pending behind it
    drive(1'b0, 1'b1, 32'd5, 32'd7, OP_ADD);
    rsp0_ready = 1'b0;
    #1 chk("stall_req0_ready", req0_ready, 1);
    @(posedge clkout);
    #1;
    req0_valid = 1'b0;
    drive(1'b1, 1'b1, 32'd2, 32'd3, OP_ADD);
    @(negedge clkout);
    wait_rsp(1'b0, "stall_rsp_seen");
    repeat (5) begin
      @(negedge clkout);
      chk("stall_valid", rsp0_valid, 1);
      chk("stall_result", rsp0_result, 12);
      chk("stall_req1_ready", req1_ready, 0);
    end
    rsp0_ready = 1'b1;
    @(posedge clkout);
    @(negedge clkout);
    chk("stall_consumed", rsp0_valid, 0);
    chk("stall_req1_accept", req1_ready, 1);
    @(posedge clkout);
    #1 req1_valid = 1'b0;
    @(negedge clkout);
    wait_rsp(1'b1, "stall_rsp1_seen");
    chk("stall_rsp1_result", rsp1_result, 5);
    @(posedge clkout);

    // reset while a response is pending aborts it
    @(negedge clkout);
    drive(1'b0, 1'b1, 32'd5, 32'd7, OP_ADD);
    rsp0_ready = 1'b0;
    @(posedge clkout);
    #1 req0_valid = 1'b0;
    @(negedge clkout);
    wait_rsp(1'b0, "abort_rsp_seen");
    rst = 1'b1;
    #1;
    chk("abort_valid", rsp0_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_alu_op", alu_op, 0);
    chk("abort_result", rsp0_result, 0);
    @(negedge clkout) rst = 1'b0;
    last_op = 6'd0;
    run_req(vt[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
